// File: rtl/stack_arbiter_if.sv
// Signal bundle between the two requesters, the arbiter and the shared LIFO stack.
// With STACK_ARB_ERRCNT_EN defined the bundle also carries the 8-bit Err_Cnt.
interface stack_arbiter_if #(
  parameter int DATA_W = 4
);
  // Requester handshake: ReqN_Push/ReqN_Pop are level requests held until a
  // one-cycle AckN (done) or ErrN (rejected) pulse; the requester drops the
  // request in the following cycle, and a request still high then is a new one.
  logic              Req0_Push;
  logic              Req0_Pop;
  logic [DATA_W-1:0] Req0_Data;
  logic              Ack0;
  logic              Err0;
  logic [DATA_W-1:0] Rd0_Data;
  logic              Req1_Push;
  logic              Req1_Pop;
  logic [DATA_W-1:0] Req1_Data;
  logic              Ack1;
  logic              Err1;
  logic [DATA_W-1:0] Rd1_Data;
  logic              Stk_Push;
  logic              Stk_Pop;
  logic [DATA_W-1:0] Stk_Data_In;
  logic [DATA_W-1:0] Stk_Data_Out;
  logic              Stk_Full;
  logic              Stk_Empty;
  logic              Busy;
`ifdef STACK_ARB_ERRCNT_EN
  logic [7:0]        Err_Cnt;
`endif

  // Arbiter side.
  modport slave (
    input  Req0_Push, Req0_Pop, Req0_Data, Req1_Push, Req1_Pop, Req1_Data,
    input  Stk_Data_Out, Stk_Full, Stk_Empty,
    output Ack0, Err0, Rd0_Data, Ack1, Err1, Rd1_Data,
    output Stk_Push, Stk_Pop, Stk_Data_In, Busy
`ifdef STACK_ARB_ERRCNT_EN
    , output Err_Cnt
`endif
  );

  // Requester / stack environment side.
  modport master (
    output Req0_Push, Req0_Pop, Req0_Data, Req1_Push, Req1_Pop, Req1_Data,
    output Stk_Data_Out, Stk_Full, Stk_Empty,
    input  Ack0, Err0, Rd0_Data, Ack1, Err1, Rd1_Data,
    input  Stk_Push, Stk_Pop, Stk_Data_In, Busy
`ifdef STACK_ARB_ERRCNT_EN
    , input Err_Cnt
`endif
  );
endinterface

// File: rtl/stack_arbiter.sv
// Round-robin two-port arbiter/sequencer in front of a shared LIFO stack.
// Optional STACK_ARB_ERRCNT_EN adds a saturating 8-bit error counter (bus.Err_Cnt).
module stack_arbiter #(
  parameter int DATA_W = 4
) (
  input  logic                 Clk,
  input  logic                 RstN,
  stack_arbiter_if.slave       bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              op_push_q, op_push_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rd0_q, rd0_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;

  logic              valid0, valid1;
  logic              sel;
  logic              sel_push;
  logic [DATA_W-1:0] sel_data;

  assign valid0 = bus.Req0_Push | bus.Req0_Pop;
  assign valid1 = bus.Req1_Push | bus.Req1_Pop;

  // Push wins when a requester raises both Push and Pop.
  always_comb begin
    sel = 1'b0;
    if (valid0 && valid1) begin
      sel = ~last_grant_q;
    end else if (valid1) begin
      sel = 1'b1;
    end
    sel_push = sel ? bus.Req1_Push : bus.Req0_Push;
    sel_data = sel ? bus.Req1_Data : bus.Req0_Data;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    op_push_d    = op_push_q;
    err_d        = err_q;
    data_d       = data_q;
    rd0_d        = rd0_q;
    rd1_d        = rd1_q;
    case (state_q)
      IDLE: begin
        if (valid0 || valid1) begin
          grant_d      = sel;
          last_grant_d = sel;
          op_push_d    = sel_push;
          data_d       = sel_push ? sel_data : '0;
          err_d        = sel_push ? bus.Stk_Full : bus.Stk_Empty;
          state_d      = (sel_push ? bus.Stk_Full : bus.Stk_Empty) ? RESP : ISSUE;
        end
      end
      ISSUE: state_d = SETTLE;
      SETTLE: begin
        // Stack output is registered, so popped data is valid here.
        if (!op_push_q) begin
          if (grant_q) rd1_d = bus.Stk_Data_Out;
          else         rd0_d = bus.Stk_Data_Out;
        end
        state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!RstN) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      op_push_q    <= 1'b0;
      err_q        <= 1'b0;
      data_q       <= '0;
      rd0_q        <= '0;
      rd1_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      op_push_q    <= op_push_d;
      err_q        <= err_d;
      data_q       <= data_d;
      rd0_q        <= rd0_d;
      rd1_q        <= rd1_d;
    end
  end

  assign bus.Stk_Push    = (state_q == ISSUE) &&  op_push_q;
  assign bus.Stk_Pop     = (state_q == ISSUE) && !op_push_q;
  assign bus.Stk_Data_In = (state_q == ISSUE) ? data_q : '0;
  assign bus.Ack0        = (state_q == RESP) && !err_q && !grant_q;
  assign bus.Ack1        = (state_q == RESP) && !err_q &&  grant_q;
  assign bus.Err0        = (state_q == RESP) &&  err_q && !grant_q;
  assign bus.Err1        = (state_q == RESP) &&  err_q &&  grant_q;
  assign bus.Rd0_Data    = rd0_q;
  assign bus.Rd1_Data    = rd1_q;
  assign bus.Busy        = (state_q != IDLE);
  assign dbg_state       = state_q;

`ifdef STACK_ARB_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((state_q == RESP) && err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!RstN) err_cnt_q <= 8'd0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign bus.Err_Cnt = err_cnt_q;
`endif

endmodule
